// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decode with handshake and multi-cycle M-op sequencing
// Optional M-extension sequencing (EXEC state, latency counter, muldiv_start) enabled by MULDIV_EN.
module alu_ctrl_seq #(
   parameter int CTR_W   = 5,
   parameter int SRC_W   = 3,
   parameter int MUL_LAT = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       alu_op,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             flush,
   output logic [SRC_W-1:0] alu_src_a,
   output logic [SRC_W-1:0] alu_src_b,
   output logic [CTR_W-1:0] alu_ctr,
   output logic             ctrl_valid,
   output logic             muldiv_start,
   output logic             busy,
   output logic             illegal
);

`ifdef MULDIV_EN
   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_DONE} state_t;
`endif

   localparam logic [SRC_W-1:0] A_PC = SRC_W'(0), A_OLDPC = SRC_W'(1), A_RS1 = SRC_W'(2), A_ZERO = SRC_W'(3);
   localparam logic [SRC_W-1:0] B_RS2 = SRC_W'(0), B_IMM = SRC_W'(1), B_FOUR = SRC_W'(2);
   localparam logic [CTR_W-1:0] C_ADD = CTR_W'(0), C_SUB = CTR_W'(1), C_SLL = CTR_W'(2), C_SLT = CTR_W'(3);
   localparam logic [CTR_W-1:0] C_SLTU = CTR_W'(4), C_XOR = CTR_W'(5), C_SRL = CTR_W'(6), C_SRA = CTR_W'(7);
   localparam logic [CTR_W-1:0] C_OR = CTR_W'(8), C_AND = CTR_W'(9), C_PASSB = CTR_W'(10);

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d, f3_q, f3_d;
   logic [6:0]         f7_q, f7_d;
   logic [SRC_W-1:0]   src_a_q, src_a_d, src_b_q, src_b_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic               ill_q, ill_d, valid_q, valid_d;
   logic [SRC_W-1:0]   dec_a, dec_b;
   logic [CTR_W-1:0]   dec_ctr, base_ctr;
   logic               dec_ill, dec_m;
`ifdef MULDIV_EN
   logic [3:0]         cnt_q, cnt_d;
   logic               start_q, start_d;
`endif

   always_comb begin
      base_ctr = C_ADD;
      case (f3_q)
         3'b000:  base_ctr = C_ADD;
         3'b001:  base_ctr = C_SLL;
         3'b010:  base_ctr = C_SLT;
         3'b011:  base_ctr = C_SLTU;
         3'b100:  base_ctr = C_XOR;
         3'b101:  base_ctr = C_SRL;
         3'b110:  base_ctr = C_OR;
         default: base_ctr = C_AND;
      endcase
   end

   // Decode works on the captured request so later input changes cannot disturb it.
   always_comb begin
      dec_a   = A_PC;
      dec_b   = B_RS2;
      dec_ctr = C_ADD;
      dec_ill = 1'b0;
      dec_m   = 1'b0;
      case (op_q)
         3'd0: dec_b = B_FOUR;
         3'd1: begin
            dec_a   = A_RS1;
            dec_ctr = C_SUB;
         end
         3'd2: begin
            dec_a   = A_RS1;
            dec_ctr = base_ctr;
            if (f7_q == 7'h00) begin
               dec_ctr = base_ctr;
            end else if (f7_q == 7'h20 && f3_q == 3'b000) begin
               dec_ctr = C_SUB;
            end else if (f7_q == 7'h20 && f3_q == 3'b101) begin
               dec_ctr = C_SRA;
`ifdef MULDIV_EN
            end else if (f7_q == 7'h01) begin
               dec_m   = 1'b1;
               dec_ctr = CTR_W'(11) + CTR_W'(f3_q);
`endif
            end else begin
               dec_ill = 1'b1;
            end
         end
         3'd3: begin
            dec_a   = A_RS1;
            dec_b   = B_IMM;
            dec_ctr = base_ctr;
            if (f3_q == 3'b001 && f7_q != 7'h00) begin
               dec_ill = 1'b1;
            end else if (f3_q == 3'b101) begin
               if (f7_q == 7'h20) dec_ctr = C_SRA;
               else if (f7_q != 7'h00) dec_ill = 1'b1;
            end
         end
         3'd4: begin
            dec_a = A_RS1;
            dec_b = B_IMM;
         end
         3'd6: begin
            dec_a   = A_ZERO;
            dec_b   = B_IMM;
            dec_ctr = C_PASSB;
         end
         default: begin
            dec_a = A_OLDPC;
            dec_b = B_IMM;
         end
      endcase
      if (dec_ill) dec_ctr = C_ADD;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      f3_d    = f3_q;
      f7_d    = f7_q;
      src_a_d = src_a_q;
      src_b_d = src_b_q;
      ctr_d   = ctr_q;
      ill_d   = ill_q;
      valid_d = 1'b0;
`ifdef MULDIV_EN
      cnt_d   = cnt_q;
      start_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // Flush wins over a simultaneous request, which is simply dropped.
            if (req_valid && !flush) begin
               state_d = S_DECODE;
               op_d    = alu_op;
               f3_d    = funct3;
               f7_d    = funct7;
            end
         end
         S_DECODE: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               src_a_d = dec_a;
               src_b_d = dec_b;
               ctr_d   = dec_ctr;
               ill_d   = dec_ill;
`ifdef MULDIV_EN
               if (dec_m) begin
                  state_d = S_EXEC;
                  cnt_d   = 4'(MUL_LAT - 1);
                  start_d = 1'b1;
               end else begin
                  state_d = S_DONE;
                  valid_d = 1'b1;
               end
`else
               state_d = S_DONE;
               valid_d = 1'b1;
`endif
            end
         end
`ifdef MULDIV_EN
         S_EXEC: begin
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         op_q    <= 3'd0;
         f3_q    <= 3'd0;
         f7_q    <= 7'd0;
         src_a_q <= A_PC;
         src_b_q <= B_RS2;
         ctr_q   <= C_ADD;
         ill_q   <= 1'b0;
         valid_q <= 1'b0;
`ifdef MULDIV_EN
         cnt_q   <= 4'd0;
         start_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         f3_q    <= f3_d;
         f7_q    <= f7_d;
         src_a_q <= src_a_d;
         src_b_q <= src_b_d;
         ctr_q   <= ctr_d;
         ill_q   <= ill_d;
         valid_q <= valid_d;
`ifdef MULDIV_EN
         cnt_q   <= cnt_d;
         start_q <= start_d;
`endif
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign alu_src_a  = src_a_q;
   assign alu_src_b  = src_b_q;
   assign alu_ctr    = ctr_q;
   assign illegal    = ill_q;
   assign ctrl_valid = valid_q;
`ifdef MULDIV_EN
   assign busy         = (state_q == S_DECODE) || (state_q == S_EXEC);
   assign muldiv_start = start_q;
`else
   assign busy         = (state_q == S_DECODE);
   assign muldiv_start = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq
// Expectations for M ops follow MULDIV_EN when the bench is built with it.
module tb_alu_ctrl_seq;
   logic       clk = 1'b0;
   logic       resetn, req_valid, flush;
   logic       req_ready, ctrl_valid, muldiv_start, busy, illegal;
   logic [2:0] alu_op, funct3;
   logic [6:0] funct7;
   logic [2:0] alu_src_a, alu_src_b;
   logic [4:0] alu_ctr;
   int         tests = 0;
   int         fails = 0;

   alu_ctrl_seq #(.CTR_W(5), .SRC_W(3), .MUL_LAT(4)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .flush(flush),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctr(alu_ctr),
      .ctrl_valid(ctrl_valid), .muldiv_start(muldiv_start), .busy(busy), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, scramble inputs after accept, and measure latency/busy/start timing.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int e_lat, input int e_busy, input int e_start,
                         input logic [2:0] ea, input logic [2:0] eb, input logic [4:0] ectr, input logic eill);
      int cyc, bcnt, scyc;
      req_valid = 1'b1;
      alu_op = op;
      funct3 = f3;
      funct7 = f7;
      tick();
      req_valid = 1'b0;
      alu_op = ~op;
      funct3 = ~f3;
      funct7 = ~f7;
      cyc = 1;
      bcnt = 0;
      scyc = 0;
      if (busy) bcnt++;
      if (muldiv_start) scyc = cyc;
      while (!ctrl_valid && cyc < 20) begin
         tick();
         cyc++;
         if (busy) bcnt++;
         if (muldiv_start) scyc = cyc;
      end
      chk({tag, "_lat"}, 32'(cyc), 32'(e_lat));
      chk({tag, "_busy"}, 32'(bcnt), 32'(e_busy));
      chk({tag, "_start"}, 32'(scyc), 32'(e_start));
      chk({tag, "_src"}, {26'd0, alu_src_a, alu_src_b}, {26'd0, ea, eb});
      chk({tag, "_ctr_ill"}, {26'd0, alu_ctr, illegal}, {26'd0, ectr, eill});
      tick();
      chk({tag, "_idle"}, {30'd0, ctrl_valid, req_ready}, 32'd1);
   endtask

   initial begin
      int acc, first_acc, last_acc, spacing_ok, vcnt;
      int mlat, mbusy, mstart;
      logic [4:0] mctr, flush_ctr;
      logic mill;
`ifdef MULDIV_EN
      mlat = 6; mbusy = 5; mstart = 2; mctr = 5'd15; mill = 1'b0;
`else
      mlat = 2; mbusy = 1; mstart = 0; mctr = 5'd0; mill = 1'b1;
`endif
      resetn = 1'b0;
      req_valid = 1'b0;
      flush = 1'b0;
      alu_op = 3'd0;
      funct3 = 3'd0;
      funct7 = 7'd0;
      tick();
      tick();
      resetn = 1'b1;
      chk("rst_ready_valid_busy", {29'd0, req_ready, ctrl_valid, busy}, 32'h4);
      chk("rst_outs", {22'd0, alu_src_a, alu_src_b, alu_ctr, illegal}, 32'd0);
      chk("rst_start", {31'd0, muldiv_start}, 32'd0);

      run_op("op0",       3'd0, 3'b000, 7'h00, 2, 1, 0, 3'd0, 3'd2, 5'd0,  1'b0);
      run_op("op1",       3'd1, 3'b000, 7'h00, 2, 1, 0, 3'd2, 3'd0, 5'd1,  1'b0);
      run_op("r_sra",     3'd2, 3'b101, 7'h20, 2, 1, 0, 3'd2, 3'd0, 5'd7,  1'b0);
      run_op("r_ill40",   3'd2, 3'b101, 7'h40, 2, 1, 0, 3'd2, 3'd0, 5'd0,  1'b1);
      run_op("r_sub",     3'd2, 3'b000, 7'h20, 2, 1, 0, 3'd2, 3'd0, 5'd1,  1'b0);
      run_op("r_and",     3'd2, 3'b111, 7'h00, 2, 1, 0, 3'd2, 3'd0, 5'd9,  1'b0);
      run_op("r_sltu20",  3'd2, 3'b011, 7'h20, 2, 1, 0, 3'd2, 3'd0, 5'd0,  1'b1);
      run_op("i_add20",   3'd3, 3'b000, 7'h20, 2, 1, 0, 3'd2, 3'd1, 5'd0,  1'b0);
      run_op("i_sra",     3'd3, 3'b101, 7'h20, 2, 1, 0, 3'd2, 3'd1, 5'd7,  1'b0);
      run_op("i_sll_ill", 3'd3, 3'b001, 7'h20, 2, 1, 0, 3'd2, 3'd1, 5'd0,  1'b1);
      run_op("i_or",      3'd3, 3'b110, 7'h7f, 2, 1, 0, 3'd2, 3'd1, 5'd8,  1'b0);
      run_op("op4",       3'd4, 3'b010, 7'h00, 2, 1, 0, 3'd2, 3'd1, 5'd0,  1'b0);
      run_op("op5",       3'd5, 3'b000, 7'h00, 2, 1, 0, 3'd1, 3'd1, 5'd0,  1'b0);
      run_op("op7",       3'd7, 3'b000, 7'h00, 2, 1, 0, 3'd1, 3'd1, 5'd0,  1'b0);
      run_op("op6",       3'd6, 3'b000, 7'h00, 2, 1, 0, 3'd3, 3'd1, 5'd10, 1'b0);
      run_op("m_xor",     3'd2, 3'b100, 7'h01, mlat, mbusy, mstart, 3'd2, 3'd0, mctr, mill);

      // Flush mid-operation: EXEC for an M op when enabled, otherwise DECODE of a base op.
      run_op("op6b",      3'd6, 3'b000, 7'h00, 2, 1, 0, 3'd3, 3'd1, 5'd10, 1'b0);
      req_valid = 1'b1;
`ifdef MULDIV_EN
      alu_op = 3'd2; funct3 = 3'b100; funct7 = 7'h01; flush_ctr = 5'd15;
      tick();
      req_valid = 1'b0;
      tick();
`else
      alu_op = 3'd2; funct3 = 3'b000; funct7 = 7'h20; flush_ctr = 5'd10;
      tick();
      req_valid = 1'b0;
`endif
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_idle", {29'd0, req_ready, busy, ctrl_valid}, 32'h4);
      chk("flush_ctr_kept", {27'd0, alu_ctr}, {27'd0, flush_ctr});
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ctrl_valid || muldiv_start) vcnt++;
      end
      chk("flush_no_valid", 32'(vcnt), 32'd0);
      run_op("op4_after", 3'd4, 3'b000, 7'h00, 2, 1, 0, 3'd2, 3'd1, 5'd0, 1'b0);

      // Flush and request together in IDLE: request dropped.
      req_valid = 1'b1;
      flush = 1'b1;
      alu_op = 3'd6;
      tick();
      req_valid = 1'b0;
      flush = 1'b0;
      chk("flush_prio", {30'd0, req_ready, busy}, 32'h2);
      tick();
      chk("flush_prio_noval", {31'd0, ctrl_valid}, 32'd0);

      // req_valid held continuously: one accept every 3 cycles.
      alu_op = 3'd0; funct3 = 3'd0; funct7 = 7'd0;
      req_valid = 1'b1;
      acc = 0; first_acc = -1; last_acc = -1; spacing_ok = 1; vcnt = 0;
      for (int i = 0; i < 9; i++) begin
         if (req_ready) begin
            if (last_acc >= 0 && (i - last_acc) != 3) spacing_ok = 0;
            if (first_acc < 0) first_acc = i;
            last_acc = i;
            acc++;
         end
         tick();
         if (ctrl_valid) vcnt++;
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_spacing", 32'(spacing_ok), 32'd1);
      chk("b2b_valids", 32'(vcnt), 32'd3);
      tick();
      tick();

      // Reset mid-operation returns to reset state.
      req_valid = 1'b1;
      alu_op = 3'd2; funct3 = 3'b110; funct7 = 7'h01;
      tick();
      req_valid = 1'b0;
      tick();
      resetn = 1'b0;
      flush = 1'b1;
      tick();
      resetn = 1'b1;
      flush = 1'b0;
      chk("rst_mid", {27'd0, req_ready, busy, ctrl_valid, muldiv_start, illegal}, 32'h10);
      chk("rst_mid_outs", {21'd0, alu_src_a, alu_src_b, alu_ctr}, 32'd0);
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ctrl_valid || busy) vcnt++;
      end
      chk("rst_mid_quiet", 32'(vcnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
